// File: rtl/cipher_frame_tx_if.sv
// cipher_frame_tx_if
// Groups the encryption-core side and receiver side signals of the serial
// frame transmitter into one bundle.
//   master : drives ena, iCiphertext, iCiphertext_counter, iReady and
//            observes the transmitter outputs (encryption core / receiver side)
//   slave  : the transmitter itself
// Signals:
//   ena                  global enable, low freezes the transmitter
//   iCiphertext          ciphertext word (MSG_SIZE bits)
//   iCiphertext_counter  ciphertext bit counter ($clog2(MSG_SIZE)+1 bits)
//   iReady               receiver ready, low stalls the serial stream
//   oData_out            serial frame bit
//   oData_flag           oData_out carries a valid, consumed frame bit
//   oBusy                high from capture until the end of the gap cycle
//   oFrame_done          pulse on the last frame bit
//   oOverrun             sticky, a ciphertext word was dropped
interface cipher_frame_tx_if #(
  parameter int unsigned MSG_SIZE = 64
) ();
  localparam int unsigned CW = $clog2(MSG_SIZE) + 1;

  logic                ena;
  logic [MSG_SIZE-1:0] iCiphertext;
  logic [CW-1:0]       iCiphertext_counter;
  logic                iReady;
  logic                oData_out;
  logic                oData_flag;
  logic                oBusy;
  logic                oFrame_done;
  logic                oOverrun;

  modport master (
    output ena, iCiphertext, iCiphertext_counter, iReady,
    input  oData_out, oData_flag, oBusy, oFrame_done, oOverrun
  );

  modport slave (
    input  ena, iCiphertext, iCiphertext_counter, iReady,
    output oData_out, oData_flag, oBusy, oFrame_done, oOverrun
  );
endinterface

// File: rtl/cipher_frame_tx.sv
// cipher_frame_tx
// Captures each completed ciphertext word from the XOR encryption core and
// sends it on one pin as a framed packet: SYNC_BYTE, payload MSB-first and,
// when FRAME_CRC_EN is defined, a CRC-8 trailer (poly 0x07, init 0x00,
// computed over the payload bits only). One extra word can wait in a
// pending buffer; a word arriving while that buffer is full is dropped and
// flagged on oOverrun.
// Build option:
//   FRAME_CRC_EN  defined -> TRAILER state and CRC present (8+MSG_SIZE+8 bits)
//                 undefined -> frame is 8+MSG_SIZE bits, no CRC logic
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    cipher_frame_tx_if.slave (see interface file for signal list)
module cipher_frame_tx #(
  parameter int unsigned MSG_SIZE  = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  cipher_frame_tx_if.slave bus
);

  localparam int unsigned CW = $clog2(MSG_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_PAYLOAD = 3'd2,
`ifdef FRAME_CRC_EN
    S_TRAILER = 3'd3,
`endif
    S_GAP     = 3'd4
  } state_t;

`ifdef FRAME_CRC_EN
  localparam state_t LAST_ST = S_TRAILER;

  // One serial CRC-8 step, polynomial x^8+x^2+x+1, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ bit_in) == 1'b1) ? 8'h07 : 8'h00);
  endfunction
`else
  localparam state_t LAST_ST = S_PAYLOAD;
`endif

  state_t              state_q, state_d;
  logic [6:0]          bit_idx_q, bit_idx_d;
  logic [MSG_SIZE-1:0] shift_q, shift_d;
  logic [MSG_SIZE-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                overrun_q, overrun_d;
  logic [CW-1:0]       cnt_prev_q, cnt_prev_d;
`ifdef FRAME_CRC_EN
  logic [7:0]          crc_q, crc_d;
`endif

  logic trig_s;
  logic in_frame_s;
  logic consume_s;
  logic data_s;
  logic last_bit_s;

  // Trigger is the rising edge of "counter reached MSG_SIZE".
  assign trig_s = (bus.iCiphertext_counter == CW'(MSG_SIZE)) &&
                  (cnt_prev_q != CW'(MSG_SIZE));

  assign in_frame_s = (state_q == S_SYNC) || (state_q == S_PAYLOAD)
`ifdef FRAME_CRC_EN
                      || (state_q == S_TRAILER)
`endif
                      ;

  // A bit is only consumed when enabled, the receiver is ready and a frame bit is presented.
  assign consume_s = bus.ena && bus.iReady && in_frame_s;

  // Current bit on the pin and whether it is the last one of its field.
  always_comb begin
    data_s     = 1'b0;
    last_bit_s = 1'b0;
    case (state_q)
      S_SYNC: begin
        data_s     = SYNC_BYTE[3'd7 - bit_idx_q[2:0]];
        last_bit_s = (bit_idx_q == 7'd7);
      end
      S_PAYLOAD: begin
        data_s     = shift_q[MSG_SIZE-1];
        last_bit_s = (bit_idx_q == 7'(MSG_SIZE - 1));
      end
`ifdef FRAME_CRC_EN
      S_TRAILER: begin
        data_s     = crc_q[7];
        last_bit_s = (bit_idx_q == 7'd7);
      end
`endif
      default: begin
        data_s     = 1'b0;
        last_bit_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for the frame FSM, capture path and pending buffer.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    cnt_prev_d = cnt_prev_q;
`ifdef FRAME_CRC_EN
    crc_d      = crc_q;
`endif
    if (bus.ena) begin
      cnt_prev_d = bus.iCiphertext_counter;
      case (state_q)
        S_IDLE: begin
          if (trig_s) begin
            shift_d   = bus.iCiphertext;
            state_d   = S_SYNC;
            bit_idx_d = 7'd0;
`ifdef FRAME_CRC_EN
            crc_d     = 8'h00;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SYNC: begin
          if (consume_s && last_bit_s) begin
            state_d   = S_PAYLOAD;
            bit_idx_d = 7'd0;
          end else if (consume_s) begin
            bit_idx_d = bit_idx_q + 7'd1;
          end else begin
            bit_idx_d = bit_idx_q;
          end
        end
        S_PAYLOAD: begin
          if (consume_s) begin
            shift_d = {shift_q[MSG_SIZE-2:0], 1'b0};
`ifdef FRAME_CRC_EN
            crc_d   = crc8_step(crc_q, shift_q[MSG_SIZE-1]);
`endif
            if (last_bit_s) begin
`ifdef FRAME_CRC_EN
              state_d = S_TRAILER;
`else
              state_d = S_GAP;
`endif
              bit_idx_d = 7'd0;
            end else begin
              bit_idx_d = bit_idx_q + 7'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
`ifdef FRAME_CRC_EN
        S_TRAILER: begin
          if (consume_s) begin
            crc_d = {crc_q[6:0], 1'b0};
            if (last_bit_s) begin
              state_d   = S_GAP;
              bit_idx_d = 7'd0;
            end else begin
              bit_idx_d = bit_idx_q + 7'd1;
            end
          end else begin
            crc_d = crc_q;
          end
        end
`endif
        S_GAP: begin
          bit_idx_d = 7'd0;
`ifdef FRAME_CRC_EN
          crc_d     = 8'h00;
`endif
          if (pend_vld_q) begin
            // Promote the pending word; a same-cycle trigger refills the freed slot.
            shift_d = pend_q;
            state_d = S_SYNC;
            if (trig_s) begin
              pend_d     = bus.iCiphertext;
              pend_vld_d = 1'b1;
            end else begin
              pend_vld_d = 1'b0;
            end
          end else if (trig_s) begin
            // Nothing pending: the new word goes straight to the shift register.
            shift_d = bus.iCiphertext;
            state_d = S_SYNC;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Mid-frame trigger: buffer the word, or drop it when the buffer is taken.
      if (trig_s && in_frame_s) begin
        if (!pend_vld_q) begin
          pend_d     = bus.iCiphertext;
          pend_vld_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        overrun_d = overrun_d;
      end
    end else begin
      cnt_prev_d = cnt_prev_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= 7'd0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      // Starting at MSG_SIZE means a counter already parked there after reset does not trigger.
      cnt_prev_q <= CW'(MSG_SIZE);
`ifdef FRAME_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      cnt_prev_q <= cnt_prev_d;
`ifdef FRAME_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign bus.oData_out   = data_s;
  assign bus.oData_flag  = consume_s;
  assign bus.oBusy       = (state_q != S_IDLE);
  assign bus.oFrame_done = consume_s && last_bit_s && (state_q == LAST_ST);
  assign bus.oOverrun    = overrun_q;

endmodule

// File: tb/tb_cipher_frame_tx.sv
module tb_cipher_frame_tx;
  localparam int MS = 64;
  localparam int CW = $clog2(MS) + 1;
`ifdef FRAME_CRC_EN
  localparam int FL = 8 + MS + 8;
`else
  localparam int FL = 8 + MS;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cipher_frame_tx_if #(.MSG_SIZE(MS)) bus ();

  cipher_frame_tx #(.MSG_SIZE(MS), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit got_q[$];
  int done_q[$];
  int spurious = 0;
  int nonflag_cnt = 0;
  int busy_low_cnt = 0;
  bit track = 1'b0;
  bit chk_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, g, e);
    end
  endtask

  // Reference CRC-8 (poly 0x07) computed byte-wise over the payload.
  function automatic logic [7:0] ref_crc(input logic [63:0] w);
    logic [7:0] c = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      c = c ^ w[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic add_frame(input logic [63:0] w);
    logic [7:0] s = 8'hA5;
    logic [7:0] c;
    c = ref_crc(w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(s[i]);
    for (int i = MS - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef FRAME_CRC_EN
    for (int i = 7; i >= 0; i--) exp_q.push_back(c[i]);
`else
    c = 8'h00;
`endif
  endtask

  task automatic sample();
    if (bus.oFrame_done && !bus.oData_flag) spurious++;
    if (chk_hold && (!bus.iReady || !bus.ena) && bus.oBusy && (got_q.size() < exp_q.size())) begin
      chk("hold_data", 64'(bus.oData_out), 64'(exp_q[got_q.size()]));
      chk("hold_flag", 64'(bus.oData_flag), 64'd0);
    end
    if (track) begin
      if (!bus.oBusy) busy_low_cnt++;
      if (!bus.oData_flag) nonflag_cnt++;
    end
    if (bus.oData_flag) begin
      got_q.push_back(bus.oData_out);
      if (bus.oFrame_done) done_q.push_back(got_q.size());
      if (track && got_q.size() == exp_q.size()) track = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(posedge clk);
    #2;
  endtask

  task automatic fire(input logic [63:0] w);
    bus.iCiphertext = w;
    bus.iCiphertext_counter = CW'(MS);
    tick();
    bus.iCiphertext_counter = CW'(MS - 1);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (bus.oBusy && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    done_q.delete();
    spurious = 0;
  endtask

  task automatic compare(input string tag, input int nframes);
    int bad = -1;
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    chk({tag, "_first_bad_bit"}, 64'(bad), 64'(-1));
    chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'(nframes));
    for (int k = 0; k < done_q.size() && k < nframes; k++)
      chk({tag, "_done_pos"}, 64'(done_q[k]), 64'(FL * (k + 1)));
    chk({tag, "_spurious_done"}, 64'(spurious), 64'd0);
  endtask

  initial begin
    logic [63:0] w1, w2, w3;
    int n;
    bus.ena = 1'b1;
    bus.iReady = 1'b1;
    bus.iCiphertext = '0;
    bus.iCiphertext_counter = '0;

    // Reset state
    #1;
    chk("rst_flag", 64'(bus.oData_flag), 64'd0);
    chk("rst_data", 64'(bus.oData_out), 64'd0);
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    chk("rst_done", 64'(bus.oFrame_done), 64'd0);
    chk("rst_ovr", 64'(bus.oOverrun), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Test 1: word 1, exact timing, gap then idle
    clear_q();
    add_frame(64'h1);
    bus.iCiphertext_counter = CW'(MS - 1);
    tick();
    fire(64'h1);
    chk("t1_lat_flag", 64'(bus.oData_flag), 64'd1);
    chk("t1_lat_data", 64'(bus.oData_out), 64'd1);
    chk("t1_lat_busy", 64'(bus.oBusy), 64'd1);
    for (int i = 0; i < FL; i++) tick();
    chk("t1_gap_flag", 64'(bus.oData_flag), 64'd0);
    chk("t1_gap_busy", 64'(bus.oBusy), 64'd1);
    tick();
    chk("t1_idle_busy", 64'(bus.oBusy), 64'd0);
    compare("t1", 1);

    // Test 2: word 0 with a 5-cycle iReady stall and a 3-cycle ena freeze
    clear_q();
    add_frame(64'h0);
    chk_hold = 1'b1;
    fire(64'h0);
    track = 1'b1; nonflag_cnt = 0; busy_low_cnt = 0;
    repeat (30) tick();
    bus.iReady = 1'b0;
    repeat (5) tick();
    bus.iReady = 1'b1;
    repeat (10) tick();
    bus.ena = 1'b0;
    repeat (3) tick();
    bus.ena = 1'b1;
    run_idle("t2", 300);
    chk_hold = 1'b0; track = 1'b0;
    chk("t2_stall_cycles", 64'(nonflag_cnt), 64'd8);
    chk("t2_busy_low", 64'(busy_low_cnt), 64'd0);
    compare("t2", 1);

    // Test 3: second word during frame 1, back-to-back frames
    clear_q();
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    add_frame(w1); add_frame(w2);
    fire(w1);
    track = 1'b1; nonflag_cnt = 0; busy_low_cnt = 0;
    repeat (20) tick();
    fire(w2);
    run_idle("t3", 400);
    track = 1'b0;
    chk("t3_gap_cycles", 64'(nonflag_cnt), 64'd1);
    chk("t3_busy_low", 64'(busy_low_cnt), 64'd0);
    chk("t3_ovr", 64'(bus.oOverrun), 64'd0);
    compare("t3", 2);

    // Test 4: three words during one frame, the third is dropped
    clear_q();
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    w3 = {$urandom, $urandom};
    add_frame(w1); add_frame(w2);
    fire(w1);
    repeat (10) tick();
    fire(w2);
    repeat (5) tick();
    chk("t4_ovr_before", 64'(bus.oOverrun), 64'd0);
    fire(w3);
    chk("t4_ovr_set", 64'(bus.oOverrun), 64'd1);
    run_idle("t4", 400);
    compare("t4", 2);
    repeat (5) tick();
    chk("t4_ovr_sticky", 64'(bus.oOverrun), 64'd1);

    // Test 5: asynchronous reset at payload bit 20
    clear_q();
    w1 = {$urandom, $urandom};
    add_frame(w1);
    fire(w1);
    n = 0;
    while (got_q.size() < 8 + 20 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reach_timeout", 64'(n < 200), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_flag", 64'(bus.oData_flag), 64'd0);
    chk("t5_rst_data", 64'(bus.oData_out), 64'd0);
    chk("t5_rst_busy", 64'(bus.oBusy), 64'd0);
    chk("t5_rst_done", 64'(bus.oFrame_done), 64'd0);
    chk("t5_rst_ovr", 64'(bus.oOverrun), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    clear_q();
    repeat (10) tick();
    chk("t5_idle_busy", 64'(bus.oBusy), 64'd0);
    chk("t5_no_bits", 64'(got_q.size()), 64'd0);
    w2 = {$urandom, $urandom};
    add_frame(w2);
    fire(w2);
    run_idle("t5", 300);
    compare("t5", 1);

    // Random words with random receiver backpressure
    for (int f = 0; f < 4; f++) begin
      clear_q();
      w1 = {$urandom, $urandom};
      add_frame(w1);
      chk_hold = 1'b1;
      fire(w1);
      n = 0;
      while (bus.oBusy && n < 600) begin
        bus.iReady = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      bus.iReady = 1'b1;
      chk_hold = 1'b0;
      chk("rnd_timeout", 64'(n < 600), 64'd1);
      compare("rnd", 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
